// File: rtl/dsp_post_adder_acc_if.sv
// Operand, control and result bundle of the DSP48A1 post-adder/accumulator stage.
interface dsp_post_adder_acc_if;
  logic        ce_c;
  logic        ce_opmode;
  logic        ce_carryin;
  logic        ce_p;
  logic [7:0]  opmode;
  logic [35:0] m;
  logic [47:0] dab;
  logic [47:0] c;
  logic [47:0] pcin;
  logic        carryin;
  logic [47:0] p;
  logic [47:0] pcout;
  logic        carryout;
  logic        carryoutf;

  modport master (
    output ce_c, ce_opmode, ce_carryin, ce_p, opmode, m, dab, c, pcin, carryin,
    input  p, pcout, carryout, carryoutf
  );

  modport slave (
    input  ce_c, ce_opmode, ce_carryin, ce_p, opmode, m, dab, c, pcin, carryin,
    output p, pcout, carryout, carryoutf
  );
endinterface

// File: rtl/dsp_post_adder_acc.sv
// DSP48A1 post-adder/accumulator: OPMODE-driven X/Z muxes, add/subtract with carry-in,
// optional C/OPMODE/carry-in/P/CARRYOUT registers and P feedback for multiply-accumulate.
module dsp_post_adder_acc #(
  parameter int    CREG        = 1,
  parameter int    OPMODEREG   = 1,
  parameter int    CARRYINREG  = 1,
  parameter string CARRYINSEL  = "OPMODE5",
  parameter int    PREG        = 1,
  parameter int    CARRYOUTREG = 1
) (
  input logic                clk,
  input logic                rst,
  dsp_post_adder_acc_if.slave bus
);

  localparam int  DATA_W        = 48;
  localparam bit  CIN_FROM_PORT = (CARRYINSEL == "CARRYIN");

  // Only opmode bits 7,5,3:0 carry meaning; the rest are kept as {sub, cin, z, x}.
  logic [5:0]        opmode_p0;
  logic [DATA_W-1:0] c_p0;
  logic              cin_p0;
  logic [DATA_W-1:0] p_p1;
  logic              cout_p1;

  logic [5:0]        op_q;
  logic [DATA_W-1:0] c_q;
  logic              cin_src;
  logic              cin_q;
  logic [DATA_W-1:0] fb;
  logic [DATA_W-1:0] x_op;
  logic [DATA_W-1:0] z_op;
  logic [DATA_W:0]   sum;
  logic              unused_opmode_bits;

  assign unused_opmode_bits = ^{bus.opmode[6], bus.opmode[4]};

  function automatic logic [DATA_W:0] post_add(input logic [DATA_W-1:0] z,
                                               input logic [DATA_W-1:0] x,
                                               input logic              cin,
                                               input logic              sub);
    logic [DATA_W:0] xk;
    xk = {1'b0, x} + {{DATA_W{1'b0}}, cin};
    if (sub) return {1'b0, z} - xk;
    else     return {1'b0, z} + xk;
  endfunction

  // Stage p0: C, OPMODE and carry-in input registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c_p0      <= '0;
      opmode_p0 <= '0;
      cin_p0    <= 1'b0;
    end else begin
      if (bus.ce_c)       c_p0      <= bus.c;
      if (bus.ce_opmode)  opmode_p0 <= {bus.opmode[7], bus.opmode[5], bus.opmode[3:0]};
      if (bus.ce_carryin) cin_p0    <= cin_src;
    end
  end

  always_comb begin
    op_q    = (OPMODEREG != 0) ? opmode_p0
                               : {bus.opmode[7], bus.opmode[5], bus.opmode[3:0]};
    c_q     = (CREG != 0) ? c_p0 : bus.c;
    cin_src = CIN_FROM_PORT ? bus.carryin : op_q[4];
    cin_q   = (CARRYINREG != 0) ? cin_p0 : cin_src;
    // Without a P register there is nothing to feed back, so selection 2 reads as zero.
    fb      = (PREG != 0) ? p_p1 : '0;

    unique case (op_q[1:0])
      2'd0:    x_op = '0;
      2'd1:    x_op = {{(DATA_W-36){1'b0}}, bus.m};
      2'd2:    x_op = fb;
      default: x_op = bus.dab;
    endcase

    unique case (op_q[3:2])
      2'd0:    z_op = '0;
      2'd1:    z_op = bus.pcin;
      2'd2:    z_op = fb;
      default: z_op = c_q;
    endcase

    sum = post_add(z_op, x_op, cin_q, op_q[5]);
  end

  // Stage p1: P and CARRYOUT result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_p1    <= '0;
      cout_p1 <= 1'b0;
    end else if (bus.ce_p) begin
      p_p1    <= sum[DATA_W-1:0];
      cout_p1 <= sum[DATA_W];
    end
  end

  always_comb begin
    bus.p         = (PREG != 0) ? p_p1 : sum[DATA_W-1:0];
    bus.pcout     = bus.p;
    bus.carryout  = (CARRYOUTREG != 0) ? cout_p1 : sum[DATA_W];
    bus.carryoutf = bus.carryout;
  end

endmodule

// File: tb/tb_dsp_post_adder_acc.sv
// Bench for dsp_post_adder_acc: a fully registered instance and a fully combinational one.
module tb_dsp_post_adder_acc;
  logic clk;
  logic rst;
  int   errors;
  int   checks;

  dsp_post_adder_acc_if bus_r ();
  dsp_post_adder_acc_if bus_c ();

  dsp_post_adder_acc dut_r (.clk(clk), .rst(rst), .bus(bus_r));

  dsp_post_adder_acc #(
    .CREG(0), .OPMODEREG(0), .CARRYINREG(0), .PREG(0), .CARRYOUTREG(0)
  ) dut_c (.clk(clk), .rst(rst), .bus(bus_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic [7:0] op, input logic [35:0] mv, input logic [47:0] dv,
                        input logic [47:0] cv, input logic [47:0] pv, input logic ci);
    bus_r.opmode = op; bus_r.m = mv; bus_r.dab = dv; bus_r.c = cv; bus_r.pcin = pv;
    bus_r.carryin = ci;
    bus_c.opmode = op; bus_c.m = mv; bus_c.dab = dv; bus_c.c = cv; bus_c.pcin = pv;
    bus_c.carryin = ci;
  endtask

  task automatic set_ce(input logic cc, input logic co, input logic ci, input logic cp);
    bus_r.ce_c = cc; bus_r.ce_opmode = co; bus_r.ce_carryin = ci; bus_r.ce_p = cp;
    bus_c.ce_c = cc; bus_c.ce_opmode = co; bus_c.ce_carryin = ci; bus_c.ce_p = cp;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // Reference: operand selection and modular arithmetic on plain 64-bit integers.
  function automatic logic [48:0] model(input logic [7:0] op, input logic [35:0] mv,
                                        input logic [47:0] dv, input logic [47:0] cv,
                                        input logic [47:0] pv, input logic [47:0] fb);
    longint unsigned x, z, k, lim;
    logic [47:0] r;
    logic co;
    lim = 64'd1 << 48;
    case (op[1:0])
      2'd0: x = 0;
      2'd1: x = 64'(mv);
      2'd2: x = 64'(fb);
      default: x = 64'(dv);
    endcase
    case (op[3:2])
      2'd0: z = 0;
      2'd1: z = 64'(pv);
      2'd2: z = 64'(fb);
      default: z = 64'(cv);
    endcase
    k = x + 64'(op[5]);
    if (op[7]) begin
      co = (z < k);
      r  = 48'((z + lim - k) % lim);
    end else begin
      co = ((z + k) >= lim);
      r  = 48'((z + k) % lim);
    end
    return {co, r};
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    set_ce(1, 1, 1, 1);
    set_in(8'h0D, 36'h7, 48'h1, 48'h20, 48'h5, 1'b1);
    tick();
    rst = 1'b0;
    repeat (3) tick();
    checks++; if (bus_r.p !== 48'h27) begin errors++; $display("FAIL pre_reset_p got=%h exp=%h", bus_r.p, 48'h27); end
    #2 rst = 1'b1;
    #1;
    checks++; if (bus_r.p !== 48'h0) begin errors++; $display("FAIL reset_p got=%h exp=0", bus_r.p); end
    checks++; if (bus_r.pcout !== 48'h0) begin errors++; $display("FAIL reset_pcout got=%h exp=0", bus_r.pcout); end
    checks++; if (bus_r.carryout !== 1'b0) begin errors++; $display("FAIL reset_carryout got=%b exp=0", bus_r.carryout); end
    checks++; if (bus_r.carryoutf !== 1'b0) begin errors++; $display("FAIL reset_carryoutf got=%b exp=0", bus_r.carryoutf); end
    tick();
    checks++; if (bus_r.p !== 48'h0) begin errors++; $display("FAIL reset_hold_p got=%h exp=0", bus_r.p); end
    rst = 1'b0;
  endtask

  task automatic test_add();
    do_reset();
    set_ce(1, 1, 1, 1);
    set_in(8'h0D, 36'h5, 48'h0, 48'h10, 48'h0, 1'b0);
    tick();
    checks++; if (bus_r.p !== 48'h0) begin errors++; $display("FAIL add_latency_p got=%h exp=0", bus_r.p); end
    tick();
    checks++; if (bus_r.p !== 48'h15) begin errors++; $display("FAIL add_p got=%h exp=%h", bus_r.p, 48'h15); end
    checks++; if (bus_r.pcout !== 48'h15) begin errors++; $display("FAIL add_pcout got=%h exp=%h", bus_r.pcout, 48'h15); end
    checks++; if (bus_r.carryout !== 1'b0) begin errors++; $display("FAIL add_carry got=%b exp=0", bus_r.carryout); end
  endtask

  task automatic test_accumulate();
    do_reset();
    set_ce(1, 1, 1, 0);
    set_in(8'h09, 36'h3, 48'h0, 48'h0, 48'h0, 1'b0);
    tick();
    set_ce(1, 1, 1, 1);
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (bus_r.p !== 48'(3 * (i + 1))) begin errors++; $display("FAIL acc_step%0d got=%h exp=%h", i, bus_r.p, 48'(3 * (i + 1))); end
    end
    set_ce(1, 1, 1, 0);
    tick();
    checks++; if (bus_r.p !== 48'd12) begin errors++; $display("FAIL acc_hold got=%h exp=%h", bus_r.p, 48'd12); end
    set_ce(1, 1, 1, 1);
    rst = 1'b1;
    #1;
    checks++; if (bus_r.p !== 48'h0) begin errors++; $display("FAIL acc_reset got=%h exp=0", bus_r.p); end
    tick();
    rst = 1'b0;
    tick();
    checks++; if (bus_r.p !== 48'h0) begin errors++; $display("FAIL acc_restart0 got=%h exp=0", bus_r.p); end
    tick();
    checks++; if (bus_r.p !== 48'd3) begin errors++; $display("FAIL acc_restart1 got=%h exp=3", bus_r.p); end
  endtask

  task automatic test_wrap();
    do_reset();
    set_ce(1, 1, 1, 1);
    set_in(8'h0F, 36'h0, 48'h1, 48'hFFFF_FFFF_FFFF, 48'h0, 1'b0);
    repeat (2) tick();
    checks++; if (bus_r.p !== 48'h0) begin errors++; $display("FAIL wrap_p got=%h exp=0", bus_r.p); end
    checks++; if (bus_r.carryout !== 1'b1) begin errors++; $display("FAIL wrap_carry got=%b exp=1", bus_r.carryout); end
    checks++; if (bus_r.carryoutf !== 1'b1) begin errors++; $display("FAIL wrap_carryf got=%b exp=1", bus_r.carryoutf); end
  endtask

  task automatic test_subtract();
    do_reset();
    set_ce(1, 1, 1, 1);
    set_in(8'hAD, 36'd30, 48'h0, 48'd100, 48'h0, 1'b0);
    repeat (3) tick();
    checks++; if (bus_r.p !== 48'd69) begin errors++; $display("FAIL sub_p got=%h exp=%h", bus_r.p, 48'd69); end
    checks++; if (bus_r.carryout !== 1'b0) begin errors++; $display("FAIL sub_carry got=%b exp=0", bus_r.carryout); end
    set_in(8'hAD, 36'd10, 48'h0, 48'd5, 48'h0, 1'b0);
    repeat (3) tick();
    checks++; if (bus_r.p !== 48'hFFFF_FFFF_FFFA) begin errors++; $display("FAIL sub_neg_p got=%h exp=%h", bus_r.p, 48'hFFFF_FFFF_FFFA); end
    checks++; if (bus_r.carryout !== 1'b1) begin errors++; $display("FAIL sub_borrow got=%b exp=1", bus_r.carryout); end
  endtask

  task automatic test_preg0();
    set_ce(1, 1, 1, 1);
    set_in(8'h2E, 36'h9, 48'h0, 48'h40, 48'h0, 1'b0);
    #1;
    checks++; if (bus_c.p !== 48'h41) begin errors++; $display("FAIL preg0_x2 got=%h exp=%h", bus_c.p, 48'h41); end
    set_in(8'h09, 36'h7, 48'h0, 48'h0, 48'h0, 1'b0);
    #1;
    checks++; if (bus_c.p !== 48'h7) begin errors++; $display("FAIL preg0_z2 got=%h exp=%h", bus_c.p, 48'h7); end
    checks++; if (bus_c.pcout !== 48'h7) begin errors++; $display("FAIL preg0_pcout got=%h exp=%h", bus_c.pcout, 48'h7); end
  endtask

  task automatic test_random_ops();
    logic [7:0]  op;
    logic [63:0] r;
    logic [35:0] mv;
    logic [47:0] dv, cv, pv;
    logic [48:0] exp_r, exp_c;
    logic [1:0]  sel;
    do_reset();
    set_ce(1, 1, 1, 1);
    for (int i = 0; i < 30; i++) begin
      op  = 8'($urandom);
      sel = 2'($urandom_range(0, 2)); op[1:0] = (sel == 2'd2) ? 2'd3 : sel;
      sel = 2'($urandom_range(0, 2)); op[3:2] = (sel == 2'd2) ? 2'd3 : sel;
      r = {$urandom(), $urandom()}; mv = r[35:0];
      r = {$urandom(), $urandom()}; dv = r[47:0];
      r = {$urandom(), $urandom()}; cv = (i % 5 == 0) ? 48'hFFFF_FFFF_FFFF : r[47:0];
      r = {$urandom(), $urandom()}; pv = r[47:0];
      set_in(op, mv, dv, cv, pv, 1'($urandom));
      exp_c = model(op, mv, dv, cv, pv, 48'h0);
      #1;
      checks++; if ({bus_c.carryout, bus_c.p} !== exp_c) begin errors++; $display("FAIL rand_comb%0d op=%h got=%b_%h exp=%b_%h", i, op, bus_c.carryout, bus_c.p, exp_c[48], exp_c[47:0]); end
      repeat (3) tick();
      exp_r = model(op, mv, dv, cv, pv, 48'h0);
      checks++; if ({bus_r.carryout, bus_r.p} !== exp_r) begin errors++; $display("FAIL rand_reg%0d op=%h got=%b_%h exp=%b_%h", i, op, bus_r.carryout, bus_r.p, exp_r[48], exp_r[47:0]); end
    end
  endtask

  task automatic test_random_accumulate();
    logic [7:0]  op;
    logic [63:0] r;
    logic [35:0] mv;
    logic [47:0] acc;
    logic        co;
    logic [48:0] nxt;
    logic        en;
    for (int pass = 0; pass < 2; pass++) begin
      do_reset();
      op = (pass == 0) ? 8'h09 : 8'h89;
      set_ce(1, 1, 1, 0);
      set_in(op, 36'h0, 48'h0, 48'h0, 48'h0, 1'b0);
      tick();
      acc = '0;
      co  = 1'b0;
      for (int i = 0; i < 16; i++) begin
        r  = {$urandom(), $urandom()};
        mv = r[35:0];
        en = ($urandom_range(0, 3) != 0);
        set_in(op, mv, 48'h0, 48'h0, 48'h0, 1'b0);
        set_ce(1, 1, 1, en);
        nxt = model(op, mv, 48'h0, 48'h0, 48'h0, acc);
        tick();
        if (en) begin
          acc = nxt[47:0];
          co  = nxt[48];
        end
        checks++; if ({bus_r.carryout, bus_r.p} !== {co, acc}) begin errors++; $display("FAIL racc%0d_%0d got=%b_%h exp=%b_%h", pass, i, bus_r.carryout, bus_r.p, co, acc); end
      end
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b1;
    set_ce(0, 0, 0, 0);
    set_in(8'h0, 36'h0, 48'h0, 48'h0, 48'h0, 1'b0);
    test_reset();
    test_add();
    test_accumulate();
    test_wrap();
    test_subtract();
    test_preg0();
    test_random_ops();
    test_random_accumulate();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
